sdram_sched: RTL
================

# sdram_sched

Single-clock command scheduler for the SDRAM frame-buffer controller. It shares the SDRAM between three requesters: the auto-refresh engine, the write-burst engine fed by the camera/ISP write FIFO, and the read-burst engine feeding the TFT read FIFO. It owns the periodic refresh timer and grants exactly one sub-controller at a time. It sits inside the SDRAM top level, between the FIFO control logic and the init/aref/write/read command generators.

## Interface
Parameters:
- REF_CYCLES, default 750: refresh interval in sys_clk cycles (7.5 us at 100 MHz); legal range 4..1023.

Ports:
- sys_clk  in  1  SDRAM controller clock (100 MHz); the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- init_end  in  1  SDRAM initialization finished; level, sampled only in IDLE.
- wr_req  in  1  write engine has a burst ready; level.
- rd_req  in  1  read engine wants a burst; level.
- aref_end  in  1  refresh sequence finished; one-cycle pulse.
- wr_end  in  1  write burst finished; one-cycle pulse.
- rd_end  in  1  read burst finished; one-cycle pulse.
- aref_en  out  1  refresh grant; registered level.
- wr_en  out  1  write grant; registered level.
- rd_en  out  1  read grant; registered level.
- state  out  3  current state: IDLE=0, ARBIT=1, AREF=2, WRITE=3, READ=4.
- ref_overrun  out  1  sticky error: refresh interval expired while a refresh was still pending.

## Operation
- States: IDLE, ARBIT, AREF, WRITE, READ.
- IDLE -> ARBIT when init_end=1. IDLE is never re-entered except by reset.
- Refresh timer ref_cnt (10 bit):
  - Held at 0 in IDLE; counts every cycle otherwise.
  - When ref_cnt = REF_CYCLES-1: ref_cnt wraps to 0 and aref_pend is set.
  - aref_pend clears on aref_end while in AREF.
  - If the timer expires while aref_pend=1: ref_overrun sets and stays set until reset; aref_pend stays 1 (one refresh, not two).
- ARBIT decision, in priority order:
  - aref_pend=1 -> AREF.
  - Else, only wr_req -> WRITE.
  - Else, only rd_req -> READ.
  - Both wr_req and rd_req -> policy set under Configuration.
  - Neither -> stay in ARBIT.
- AREF / WRITE / READ hold until the matching end pulse, then go to ARBIT.
  - Bursts are never preempted. A refresh that becomes due mid-burst waits for the end pulse.
  - End pulses that do not match the current state are ignored.
- Grant outputs equal the registered decode of the state: aref_en=(AREF), wr_en=(WRITE), rd_en=(READ). At most one is high at any time.
- Reset values: state=IDLE, all grants 0, ref_cnt=0, aref_pend=0, ref_overrun=0, last_grant=READ.
- A reset asserted mid-burst drops all grants asynchronously. Sub-controllers are reset by the same signal.

## Timing
- Decision is made in an ARBIT cycle. state and the grant change at the following edge, giving a 1-cycle latency from request to grant.
- End pulse sampled at edge M: the grant is low and state=ARBIT after M. The next grant can be high at the earliest after edge M+1, so ARBIT always lasts at least 1 cycle between grants.
- aref_pend sets at the wrap edge and is visible to ARBIT in the next cycle.
- A wrap and aref_end on the same edge: aref_end clears the old pending, the wrap sets a new one, so aref_pend=1 and ref_overrun is not set.

## Configuration
- SDRAM_SCHED_RR_EN defined: round-robin arbitration between write and read.
  - A 1-bit last_grant updates on each WRITE/READ entry.
  - When both request, the side not served last wins.
  - After reset, write wins the first tie.
- Not defined: fixed priority, write always beats read. last_grant is not implemented.

## Test plan
- Init gating: init_end=0 for 50 cycles with wr_req=1 -> state=0, no grant, ref_cnt=0. Raise init_end -> state=1 on the next edge, wr_en=1 one edge later.
- Refresh period (REF_CYCLES=16, no requests): aref_en rises every 16 cycles. Return aref_end 3 cycles after each grant -> grant low the next edge, ref_overrun stays 0.
- Refresh not preempting: wr_en granted, timer expires mid-burst, wr_end 20 cycles later -> wr_en low, 1 ARBIT cycle, then aref_en=1 even though wr_req=1.
- Overrun (REF_CYCLES=16): hold aref_end low for 40 cycles after the aref grant -> ref_overrun=1 at the second expiry and stays 1 after aref_end.
- Contention (wr_req=rd_req=1, end pulses 4 cycles after each grant): with SDRAM_SCHED_RR_EN -> grants alternate W,R,W,R. Without it -> W,W,W,W.
- Reset mid-READ: drop sys_rst_n while rd_en=1 -> rd_en=0, state=0, ref_overrun=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: refresh timer plus single-grant arbitration of refresh, write and read engines.
// Optional macro SDRAM_SCHED_RR_EN selects round-robin write/read tie-breaking (default: write wins).
module sdram_sched #(
  parameter int REF_CYCLES = 750
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_end,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       aref_end,
  input  logic       wr_end,
  input  logic       rd_end,
  output logic       aref_en,
  output logic       wr_en,
  output logic       rd_en,
  output logic [2:0] state,
  output logic       ref_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic [9:0] REF_LAST = 10'(REF_CYCLES - 1);

  state_t     cur;
  state_t     nxt;
  logic [9:0] ref_cnt;
  logic       aref_pend;
  logic       wrap;
  logic       aref_clr;
  logic       wr_wins;

  assign wrap     = (cur != IDLE) && (ref_cnt == REF_LAST);
  assign aref_clr = (cur == AREF) && aref_end;
  assign state    = cur;

  // Refresh timer; a wrap on the same edge as aref_end re-arms the pending flag without an overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt     <= '0;
      aref_pend   <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (cur == IDLE)
        ref_cnt <= '0;
      else if (wrap)
        ref_cnt <= '0;
      else
        ref_cnt <= ref_cnt + 10'd1;
      aref_pend <= wrap | (aref_pend & ~aref_clr);
      if (wrap && aref_pend && !aref_clr)
        ref_overrun <= 1'b1;
    end
  end

`ifdef SDRAM_SCHED_RR_EN
  // last_grant: 1 = read served last, so write wins the first tie after reset.
  logic last_grant;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      last_grant <= 1'b1;
    else if (cur == ARBIT && nxt == WRITE)
      last_grant <= 1'b0;
    else if (cur == ARBIT && nxt == READ)
      last_grant <= 1'b1;
  end

  assign wr_wins = last_grant;
`else
  assign wr_wins = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cur <= IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (init_end) nxt = ARBIT;
      ARBIT: begin
        if (aref_pend)
          nxt = AREF;
        else if (wr_req && (!rd_req || wr_wins))
          nxt = WRITE;
        else if (rd_req)
          nxt = READ;
      end
      AREF:  if (aref_end) nxt = ARBIT;
      WRITE: if (wr_end)   nxt = ARBIT;
      READ:  if (rd_end)   nxt = ARBIT;
      default: nxt = IDLE;
    endcase
  end

  // Grants are registered from the next state so they track the state register exactly.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= (nxt == AREF);
      wr_en   <= (nxt == WRITE);
      rd_en   <= (nxt == READ);
    end
  end

endmodule
